// File: rtl/rgb_stream_packer.sv
// ---------------------------------------------------------------------------
// rgb_stream_packer
//
// Packs a stream of 24-bit RGB pixels (one per valid/ready handshake) into
// 32-bit AXI4-Stream words, four pixels per three words. Bytes go out
// little-endian in pixel order: b, g, r of pixel 0 first.
//   - out_stream_tuser marks the first word of a frame (the pixel with sof).
//   - out_stream_tlast marks the word that carries the last byte of a line.
//   - A line that ends off a 4-pixel boundary is completed by one extra
//     zero-padded word with tlast=1, and the sticky misaligned flag is set.
//
// Ports
//   aclk, aresetn          clock, asynchronous active-low reset
//   r, g, b                pixel colour components
//   valid, sof, eol        pixel qualifiers
//   in_stream_ready        pixel accepted when valid && in_stream_ready
//   out_stream_t*          AXI4-Stream master (tkeep is always 4'hF)
//   misaligned             sticky: eol off a group boundary or sof mid-group
// ---------------------------------------------------------------------------
module rgb_stream_packer #(
    parameter int PHASES = 4
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  r,
    input  logic [7:0]  g,
    input  logic [7:0]  b,
    input  logic        valid,
    input  logic        sof,
    input  logic        eol,
    output logic        in_stream_ready,
    output logic [31:0] out_stream_tdata,
    output logic [3:0]  out_stream_tkeep,
    output logic        out_stream_tlast,
    output logic        out_stream_tuser,
    output logic        out_stream_tvalid,
    input  logic        out_stream_tready,
    output logic        misaligned
);

    localparam logic [1:0] LAST_PHASE = 2'(PHASES - 1);

    typedef enum logic {
        ST_PACK  = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  phase_q, phase_d;
    logic [23:0] carry_q, carry_d;
    logic        sof_pend_q, sof_pend_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] tdata_q, tdata_d;
    logic        tlast_q, tlast_d;
    logic        tuser_q, tuser_d;
    logic        tvalid_q, tvalid_d;

    logic [23:0] pix;
    logic        out_free;
    logic        accept;
    logic [1:0]  eff_phase;
    logic        load;
    logic [31:0] word;
    logic        word_last;

    assign pix      = {r, g, b};
    assign out_free = !tvalid_q || out_stream_tready;

    // A phase-0 pixel never produces a word (unless it is an eol, which only
    // moves to FLUSH), so it can be taken even while the output is stalled.
    assign in_stream_ready = aresetn && (state_q == ST_PACK) &&
                             ((phase_q == 2'd0) || out_free);
    assign accept = valid && in_stream_ready;

    // A sof restarts the group: that pixel is always packed as phase 0.
    assign eff_phase = sof ? 2'd0 : phase_q;

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        carry_d      = carry_q;
        sof_pend_d   = sof_pend_q;
        misaligned_d = misaligned_q;
        tdata_d      = tdata_q;
        tlast_d      = tlast_q;
        tuser_d      = tuser_q;
        tvalid_d     = tvalid_q && !out_stream_tready;
        load         = 1'b0;
        word         = '0;
        word_last    = 1'b0;

        case (state_q)
            ST_PACK: begin
                if (accept) begin
                    if (sof) begin
                        sof_pend_d = 1'b1;
                        if (phase_q != 2'd0) begin
                            misaligned_d = 1'b1;
                        end
                    end

                    // carry holds only the not-yet-emitted bytes, zero-extended,
                    // so FLUSH can emit it directly.
                    case (eff_phase)
                        2'd0: begin
                            carry_d = pix;
                        end
                        2'd1: begin
                            load    = 1'b1;
                            word    = {pix[7:0], carry_q};
                            carry_d = {8'h00, pix[23:8]};
                        end
                        2'd2: begin
                            load    = 1'b1;
                            word    = {pix[15:0], carry_q[15:0]};
                            carry_d = {16'h0000, pix[23:16]};
                        end
                        default: begin
                            load      = 1'b1;
                            word      = {pix, carry_q[7:0]};
                            word_last = eol;
                        end
                    endcase

                    if (eff_phase == LAST_PHASE) begin
                        phase_d = 2'd0;
                    end else if (eol) begin
                        phase_d      = 2'd0;
                        state_d      = ST_FLUSH;
                        misaligned_d = 1'b1;
                    end else begin
                        phase_d = eff_phase + 2'd1;
                    end
                end
            end

            ST_FLUSH: begin
                if (out_free) begin
                    load      = 1'b1;
                    word      = {8'h00, carry_q};
                    word_last = 1'b1;
                    state_d   = ST_PACK;
                end
            end

            default: begin
                state_d = ST_PACK;
            end
        endcase

        if (load) begin
            tdata_d    = word;
            tlast_d    = word_last;
            tuser_d    = sof_pend_q;
            sof_pend_d = 1'b0;
            tvalid_d   = 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_PACK;
            phase_q      <= 2'd0;
            carry_q      <= '0;
            sof_pend_q   <= 1'b0;
            misaligned_q <= 1'b0;
            tdata_q      <= '0;
            tlast_q      <= 1'b0;
            tuser_q      <= 1'b0;
            tvalid_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            carry_q      <= carry_d;
            sof_pend_q   <= sof_pend_d;
            misaligned_q <= misaligned_d;
            tdata_q      <= tdata_d;
            tlast_q      <= tlast_d;
            tuser_q      <= tuser_d;
            tvalid_q     <= tvalid_d;
        end
    end

    assign out_stream_tdata  = tdata_q;
    assign out_stream_tkeep  = 4'hF;
    assign out_stream_tlast  = tlast_q;
    assign out_stream_tuser  = tuser_q;
    assign out_stream_tvalid = tvalid_q;
    assign misaligned        = misaligned_q;

endmodule

// File: tb/tb_rgb_stream_packer.sv
// ---------------------------------------------------------------------------
// Bench for rgb_stream_packer. The reference model treats each line as a
// byte stream (b, g, r per pixel), cuts it into little-endian 32-bit words,
// zero-pads the tail at eol and tags the first word after a sof.
// ---------------------------------------------------------------------------
module tb_rgb_stream_packer;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [7:0]  r, g, b;
    logic        valid, sof, eol;
    logic        in_stream_ready;
    logic [31:0] out_stream_tdata;
    logic [3:0]  out_stream_tkeep;
    logic        out_stream_tlast, out_stream_tuser, out_stream_tvalid;
    logic        out_stream_tready;
    logic        misaligned;

    rgb_stream_packer dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .r                 (r),
        .g                 (g),
        .b                 (b),
        .valid             (valid),
        .sof               (sof),
        .eol               (eol),
        .in_stream_ready   (in_stream_ready),
        .out_stream_tdata  (out_stream_tdata),
        .out_stream_tkeep  (out_stream_tkeep),
        .out_stream_tlast  (out_stream_tlast),
        .out_stream_tuser  (out_stream_tuser),
        .out_stream_tvalid (out_stream_tvalid),
        .out_stream_tready (out_stream_tready),
        .misaligned        (misaligned)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {
        logic [23:0] p;
        logic        sof;
        logic        eol;
    } pix_t;

    int n_cmp = 0;
    int n_err = 0;

    pix_t        pq[$];
    logic [7:0]  mb[$];
    logic        m_pend, m_mis;
    logic [31:0] exp_data[$];
    logic        exp_last[$], exp_user[$];
    logic [31:0] obs_data[$];
    logic        obs_last[$], obs_user[$];
    logic [31:0] lit[$];
    int          rdy_low;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mb.delete();
        m_pend = 1'b0;
        m_mis  = 1'b0;
        exp_data.delete();
        exp_last.delete();
        exp_user.delete();
    endtask

    task automatic model_emit(input logic [31:0] w, input logic last);
        exp_data.push_back(w);
        exp_last.push_back(last);
        exp_user.push_back(m_pend);
        m_pend = 1'b0;
    endtask

    task automatic model_accept(input pix_t x);
        logic [31:0] w;
        if (x.sof) begin
            if (mb.size() != 0) m_mis = 1'b1;
            mb.delete();
            m_pend = 1'b1;
        end
        mb.push_back(x.p[7:0]);
        mb.push_back(x.p[15:8]);
        mb.push_back(x.p[23:16]);
        while (mb.size() >= 4) begin
            w = {mb[3], mb[2], mb[1], mb[0]};
            repeat (4) void'(mb.pop_front());
            model_emit(w, 1'b0);
        end
        if (x.eol) begin
            if (mb.size() != 0) begin
                m_mis = 1'b1;
                w = '0;
                for (int i = 0; i < mb.size(); i++) w[8*i +: 8] = mb[i];
                mb.delete();
                model_emit(w, 1'b1);
            end else begin
                exp_last[exp_last.size()-1] = 1'b1;
            end
        end
    endtask

    task automatic add_pix(input logic [23:0] p, input logic s, input logic e);
        pix_t x;
        x.p = p; x.sof = s; x.eol = e;
        pq.push_back(x);
    endtask

    // tr_mode: 0 = tready high, 1 = random tready, 2 = 5-cycle stall after word 2
    task automatic run_scn(input string tag, input int tr_mode, input int vld_pct, input int budget);
        int          cyc = 0;
        int          hs = 0;
        int          stall = 0;
        logic        have = 1'b0;
        logic        hold = 1'b0;
        logic [31:0] h_data;
        logic        h_last, h_user;
        pix_t        cur;
        cur = '0;
        rdy_low = 0;
        obs_data.delete(); obs_last.delete(); obs_user.delete();
        while ((pq.size() != 0 || have || exp_data.size() != 0) && cyc < budget) begin
            if (!have && pq.size() != 0 && ($urandom_range(99) < vld_pct)) begin
                cur  = pq.pop_front();
                have = 1'b1;
            end
            valid = have;
            {r, g, b} = have ? cur.p : $urandom();
            sof = have && cur.sof;
            eol = have && cur.eol;
            case (tr_mode)
                0: out_stream_tready = 1'b1;
                1: out_stream_tready = ($urandom_range(1) == 1);
                default: begin
                    out_stream_tready = !(hs >= 2 && stall < 5);
                    if (!out_stream_tready) stall++;
                end
            endcase
            @(negedge aclk);
            if (!in_stream_ready) rdy_low++;
            if (hold) begin
                check_val({tag, "_hold_valid"}, out_stream_tvalid, 1);
                check_val({tag, "_hold_data"}, out_stream_tdata, h_data);
                check_val({tag, "_hold_flags"}, {out_stream_tlast, out_stream_tuser}, {h_last, h_user});
            end
            if (out_stream_tvalid && out_stream_tready) begin
                hs++;
                obs_data.push_back(out_stream_tdata);
                obs_last.push_back(out_stream_tlast);
                obs_user.push_back(out_stream_tuser);
                check_val({tag, "_tkeep"}, out_stream_tkeep, 4'hF);
                if (exp_data.size() == 0) begin
                    check_val({tag, "_extra_word"}, out_stream_tdata, 64'hDEAD_0000_0000);
                end else begin
                    check_val({tag, "_data"}, out_stream_tdata, exp_data.pop_front());
                    check_val({tag, "_tlast"}, out_stream_tlast, exp_last.pop_front());
                    check_val({tag, "_tuser"}, out_stream_tuser, exp_user.pop_front());
                end
            end
            hold   = out_stream_tvalid && !out_stream_tready;
            h_data = out_stream_tdata;
            h_last = out_stream_tlast;
            h_user = out_stream_tuser;
            if (valid && in_stream_ready) begin
                model_accept(cur);
                have = 1'b0;
            end
            @(posedge aclk);
            #1;
            cyc++;
        end
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
        check_val({tag, "_done_in_budget"}, cyc < budget, 1);
        check_val({tag, "_misaligned"}, misaligned, m_mis);
    endtask

    task automatic check_words(input string tag, input int last_idx, input int user_idx);
        check_val({tag, "_count"}, obs_data.size(), lit.size());
        for (int i = 0; i < lit.size() && i < obs_data.size(); i++) begin
            check_val($sformatf("%s_w%0d", tag, i), obs_data[i], lit[i]);
            check_val($sformatf("%s_l%0d", tag, i), obs_last[i], i == last_idx);
            check_val($sformatf("%s_u%0d", tag, i), obs_user[i], i == user_idx);
        end
    endtask

    task automatic load_aligned();
        for (int i = 0; i < 8; i++) add_pix({3{8'(i)}}, i == 0, i == 7);
        lit = '{32'h01000000, 32'h02020101, 32'h03030302,
                32'h05040404, 32'h06060505, 32'h07070706};
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lines, len, words, lasts, users;
        aresetn = 1'b0;
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
        r = 8'h0; g = 8'h0; b = 8'h0;
        out_stream_tready = 1'b1;
        model_reset();

        // reset state
        repeat (3) @(posedge aclk);
        #1;
        check_val("rst_tvalid", out_stream_tvalid, 0);
        check_val("rst_tdata", out_stream_tdata, 0);
        check_val("rst_flags", {out_stream_tlast, out_stream_tuser}, 0);
        check_val("rst_misaligned", misaligned, 0);
        check_val("rst_ready", in_stream_ready, 0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // aligned line
        load_aligned();
        run_scn("aligned", 0, 100, 200);
        check_words("aligned", 5, 0);
        check_val("aligned_ready_low", rdy_low, 0);

        // backpressure
        load_aligned();
        run_scn("bp", 2, 100, 200);
        check_words("bp", 5, 0);
        check_val("bp_ready_went_low", rdy_low != 0, 1);

        // eol at phase 0 (5 pixels)
        for (int i = 1; i <= 5; i++) add_pix({3{8'(i)}}, 1'b0, i == 5);
        lit = '{32'h02010101, 32'h03030202, 32'h04040403, 32'h00050505};
        run_scn("eol_ph0", 0, 100, 200);
        check_words("eol_ph0", 3, -1);
        check_val("eol_ph0_ready_low", rdy_low, 1);

        // eol at phase 2 (3 pixels)
        for (int i = 1; i <= 3; i++) add_pix({3{8'(i)}}, 1'b0, i == 3);
        lit = '{32'h02010101, 32'h03030202, 32'h00000003};
        run_scn("eol_ph2", 0, 100, 200);
        check_words("eol_ph2", 2, -1);
        check_val("eol_ph2_ready_low", rdy_low, 1);

        // reset mid-group: two pixels accepted with the sink stalled
        out_stream_tready = 1'b0;
        valid = 1'b1; {r, g, b} = 24'h111111;
        @(posedge aclk); #1;
        {r, g, b} = 24'h222222;
        @(posedge aclk); #1;
        valid = 1'b0;
        aresetn = 1'b0;
        #1;
        check_val("midrst_tvalid", out_stream_tvalid, 0);
        check_val("midrst_misaligned", misaligned, 0);
        check_val("midrst_ready", in_stream_ready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        model_reset();
        @(posedge aclk); #1;
        load_aligned();
        run_scn("after_rst", 0, 100, 200);
        check_words("after_rst", 5, 0);

        // two 640-pixel lines, random ready/valid
        for (int l = 0; l < 2; l++)
            for (int i = 0; i < 640; i++)
                add_pix($urandom(), l == 0 && i == 0, i == 639);
        run_scn("long", 1, 80, 20000);
        words = obs_data.size();
        lasts = 0;
        users = 0;
        for (int i = 0; i < words; i++) begin
            lasts += int'(obs_last[i]);
            users += int'(obs_user[i]);
        end
        check_val("long_words", words, 960);
        check_val("long_tlast_count", lasts, 2);
        check_val("long_tuser_count", users, 1);
        if (words > 0) check_val("long_first_tuser", obs_user[0], 1);

        // random short lines with occasional mid-line sof
        lines = 40;
        for (int l = 0; l < lines; l++) begin
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++)
                add_pix($urandom(), (l == 0 && i == 0) || ($urandom_range(9) == 0), i == len - 1);
        end
        run_scn("mixed", 1, 70, 20000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
